note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a stored song through the four-voice synthesizer. Steps through a note memory one 32-bit word at a time, splits each word into four 8-bit frequency codes, and holds them on `freq1`..`freq4` for a programmable number of clock cycles. Sits between the note storage RAM (1-cycle synchronous read) and the per-voice square-wave generators. Adds start/stop, looping and end-of-song detection to the four-voice frequency-control path.

## Interface
- `ADDR_W`, 8, note memory address width (song length up to 2^ADDR_W words)
- `TICK_W`, 16, width of the step-length count
---
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begins playback from address 0
- `stop`  in  1  single-cycle pulse; aborts playback
- `loop_en`  in  1  on end-of-song, restart at address 0 instead of finishing
- `step_ticks`  in  TICK_W  hold length of each step in cycles; sampled on accepted `start`
- `mem_addr`  out  ADDR_W  note memory read address
- `mem_rd`  out  1  read enable; data valid on `mem_data` the following cycle
- `mem_data`  in  32  note word: [7:0] voice1, [15:8] voice2, [23:16] voice3, [31:24] voice4
- `freq1`..`freq4`  out  8 each  frequency codes to voices; 0 = rest
- `step_strobe`  out  1  one-cycle pulse in the cycle new codes first appear
- `busy`  out  1  high from accepted `start` until IDLE or DONE
- `done`  out  1  high in DONE; cleared by the next accepted `start`

## Operation
- States: IDLE, FETCH, LOAD, HOLD, DONE.
- IDLE: freqs 0, `busy`=0. If `start` is high and `step_ticks`≠0: latch `step_ticks` into `tick_len`, set addr=0, go to FETCH. `start` with `step_ticks`=0 is ignored.
- FETCH (1 cycle): `mem_rd`=1 and `mem_addr`=addr. Go to LOAD.
- LOAD (1 cycle): examine `mem_data`.
  - 32'hFFFF_FFFF is the end marker.
    - End marker with `loop_en`=1 and addr≠0: set addr=0, go to FETCH. No strobe; freqs keep their previous values.
    - End marker with `loop_en`=0, or at addr 0: go to DONE.
  - Any other word: register the four bytes onto `freq1`..`freq4`, pulse `step_strobe`, set counter=`tick_len`−1, set addr=addr+1, go to HOLD.
- Address wrap: addr increments modulo 2^ADDR_W. After the last word it wraps to 0 and playback continues.
- HOLD: counter decrements each cycle. In the cycle counter==0, go to FETCH. HOLD therefore lasts exactly `tick_len` cycles.
- DONE: freqs 0, `done`=1, `busy`=0. `start` behaves as in IDLE and clears `done`.
- `stop`: in FETCH, LOAD or HOLD, the next state is IDLE. Freqs clear to 0, no strobe, `mem_rd`=0. In IDLE or DONE `stop` is ignored.
- Simultaneous `start` and `stop`: `stop` wins.
- `start` while `busy` is ignored.
- `step_ticks` changes after latching have no effect until the next accepted `start`.
- Code 0 passes through unchanged (rest).

## Timing
- Reset (async assert, sync release): state IDLE; `freq1`..`freq4`=0, `mem_addr`=0, `mem_rd`=0, `step_strobe`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` accepted at edge k:
  - FETCH in cycle k+1 with `mem_rd`=1 and `mem_addr`=0.
  - LOAD in cycle k+2.
  - First codes and `step_strobe` visible in cycle k+3.
- Step period: codes change every `tick_len`+2 cycles (HOLD plus FETCH and LOAD overhead).
- Loop restart: end-marker LOAD, then FETCH of addr 0, then LOAD. The last step is extended by 2 cycles.
- End of song without loop: `done` rises and freqs go to 0 in the cycle after the end-marker LOAD.
- `stop` at edge k: freqs 0 and `busy`=0 from cycle k+1.
- `busy`=1 from cycle k+1 after an accepted `start`, through the cycle before IDLE/DONE.

## Test plan
- Basic playback: memory [0]=32'h04030201, [1]=32'h08070605, [2]=32'hFFFFFFFF; `step_ticks`=4, `loop_en`=0, pulse `start`.
  - freqs = 01/02/03/04 for 6 cycles, then 05/06/07/08 for 6 cycles.
  - Then `done`=1 and freqs 0.
  - Exactly 2 `step_strobe` pulses.
- Loop: same memory with `loop_en`=1.
  - Sequence 01..04, 05..08, 01..04 repeats.
  - Second-step dwell is 8 cycles; `done` never asserts.
- End marker at addr 0 with `loop_en`=1.
  - DONE reached 3 cycles after `start`; no strobe; no endless fetching.
- Stop mid-HOLD: `step_ticks`=100, pulse `stop` 20 cycles into step 0.
  - Next cycle: freqs 0, `busy`=0, `mem_rd`=0.
  - A later `start` replays from address 0.
- Ignored inputs:
  - `start` with `step_ticks`=0 leaves the block in IDLE.
  - `start` while busy does not restart.
  - Changing `step_ticks` mid-song keeps the 6-cycle period.
  - `start` and `stop` in the same cycle while busy gives IDLE.
- Async reset during HOLD: drop `reset_n` mid-cycle.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, no activity until `start`.

Source files
------------

// File: rtl/note_sequencer_if.sv
// note_sequencer_if
// Note-memory read port shared by the sequencer and the song RAM.
// The RAM has a 1-cycle synchronous read: mem_data is valid in the cycle
// after mem_rd is high with mem_addr.
//   mem_addr  sequencer -> RAM  read address
//   mem_rd    sequencer -> RAM  read enable
//   mem_data  RAM -> sequencer  note word {voice4, voice3, voice2, voice1}
// Modports: master = sequencer side, slave = memory side.
interface note_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
// Plays a song stored one 32-bit word per step in the note memory. Each word
// carries four 8-bit frequency codes that are held on freq1..freq4 for
// tick_len cycles, then the next word is fetched. 32'hFFFF_FFFF marks the end
// of the song: either playback finishes (DONE) or restarts at address 0.
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   start, stop           single-cycle control pulses
//   loop_en               restart at address 0 on the end marker
//   step_ticks            step length in cycles, latched on accepted start
//   mem                   note-memory read port (master side)
//   freq1..freq4          registered frequency codes, 0 = rest
//   step_strobe           one-cycle pulse when new codes first appear
//   busy, done            playback status
module note_sequencer #(
  parameter int ADDR_W = 8,
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [TICK_W-1:0] step_ticks,
  note_sequencer_if.master  mem,
  output logic [7:0]        freq1,
  output logic [7:0]        freq2,
  output logic [7:0]        freq3,
  output logic [7:0]        freq4,
  output logic              step_strobe,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, HOLD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [TICK_W-1:0] tick_len_reg, tick_len_next;
  logic [TICK_W-1:0] count_reg, count_next;
  logic [31:0]       freq_reg, freq_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              strobe_reg, strobe_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic start_ok;
  logic end_marker;

  // stop takes priority over a coincident start in every state, so a
  // start+stop pulse never launches playback.
  assign start_ok   = start && !stop && (step_ticks != '0);
  assign end_marker = (mem.mem_data == 32'hFFFF_FFFF);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    tick_len_next = tick_len_reg;
    count_next    = count_reg;
    freq_next     = freq_reg;
    strobe_next   = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start_ok) begin
          tick_len_next = step_ticks;
          addr_next     = '0;
          state_next    = FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        if (end_marker) begin
          // A marker at address 0 means an empty song; looping it would
          // fetch forever, so it always finishes.
          if (loop_en && (addr_reg != '0)) begin
            addr_next  = '0;
            state_next = FETCH;
          end else begin
            state_next = DONE;
          end
        end else begin
          freq_next   = mem.mem_data;
          strobe_next = 1'b1;
          count_next  = tick_len_reg - TICK_W'(1);
          addr_next   = addr_reg + ADDR_W'(1);
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (count_reg == '0) state_next = FETCH;
        else                 count_next = count_reg - TICK_W'(1);
      end
      default: state_next = IDLE;
    endcase

    if (stop && (state_reg inside {FETCH, LOAD, HOLD})) begin
      state_next  = IDLE;
      strobe_next = 1'b0;
    end

    // Voices are silent whenever playback is not running.
    if ((state_next == IDLE) || (state_next == DONE)) freq_next = '0;

    mem_rd_next = (state_next == FETCH);
    busy_next   = (state_next inside {FETCH, LOAD, HOLD});
    done_next   = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      tick_len_reg <= '0;
      count_reg    <= '0;
      freq_reg     <= '0;
      mem_rd_reg   <= 1'b0;
      strobe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      tick_len_reg <= tick_len_next;
      count_reg    <= count_next;
      freq_reg     <= freq_next;
      mem_rd_reg   <= mem_rd_next;
      strobe_reg   <= strobe_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // addr_reg is the fetch address while in FETCH, so it drives the RAM directly.
  assign mem.mem_addr = addr_reg;
  assign mem.mem_rd   = mem_rd_reg;
  assign freq1        = freq_reg[7:0];
  assign freq2        = freq_reg[15:8];
  assign freq3        = freq_reg[23:16];
  assign freq4        = freq_reg[31:24];
  assign step_strobe  = strobe_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Scoreboard bench: each playback is turned into a list of expected
// (cycle, word) strobe events and a done event by a timeline model of the
// song; a separate monitor pops and compares whenever the DUT strobes or
// raises done, and checks every cycle that the held codes are correct.
module tb_note_sequencer;

  localparam int ADDR_W = 8;
  localparam int TICK_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [TICK_W-1:0] step_ticks;
  logic [7:0]        freq1, freq2, freq3, freq4;
  logic              step_strobe;
  logic              busy;
  logic              done;

  note_sequencer_if #(.ADDR_W(ADDR_W)) mif ();

  note_sequencer #(.ADDR_W(ADDR_W), .TICK_W(TICK_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .step_ticks  (step_ticks),
    .mem         (mif.master),
    .freq1       (freq1),
    .freq2       (freq2),
    .freq3       (freq3),
    .freq4       (freq4),
    .step_strobe (step_strobe),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int          cyc;
    logic [31:0] word;
    bit          is_done;
  } ev_t;

  ev_t         expq[$];
  logic [31:0] mem [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Song RAM with 1-cycle synchronous read.
  always @(posedge clk) if (mif.mem_rd) mif.mem_data <= mem[mif.mem_addr];

  // Timeline of one playback. t is the FETCH cycle of the next word; a word
  // read in LOAD at t+1 shows up (or done rises) in cycle t+2. Events at or
  // after cutoff are suppressed by a stop (or reset) taking effect then.
  task automatic model(input int s, input int ticks, input bit lp, input int cutoff);
    int  addr = 0;
    int  t = s;
    ev_t e;
    while (t + 2 < cutoff) begin
      if (mem[addr] == 32'hFFFF_FFFF) begin
        if (lp && addr != 0) begin
          addr = 0;
          t    = t + 2;
        end else begin
          e.cyc = t + 2; e.word = 32'h0; e.is_done = 1'b1;
          expq.push_back(e);
          break;
        end
      end else begin
        e.cyc = t + 2; e.word = mem[addr]; e.is_done = 1'b0;
        expq.push_back(e);
        addr = (addr + 1) % DEPTH;
        t    = t + 2 + ticks;
      end
    end
  endtask

  // Monitor: event comparison plus per-cycle hold check.
  initial begin
    logic [31:0] cur = 32'h0;
    logic [31:0] fq;
    bit          done_prev = 1'b0;
    bit          got_done;
    ev_t         e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cur = 32'h0;
        done_prev = 1'b0;
      end else begin
        fq = {freq4, freq3, freq2, freq1};
        got_done = done && !done_prev;
        if (step_strobe || got_done) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected cyc=%0d strobe=%0b done=%0b freqs=%h, required no event",
                     cyc, step_strobe, done, fq);
          end else begin
            e = expq.pop_front();
            if (e.cyc != cyc || e.is_done != got_done || (!e.is_done && fq != e.word)) begin
              errors++;
              $display("FAIL event cyc=%0d done=%0b freqs=%h, required cyc=%0d done=%0b freqs=%h",
                       cyc, got_done, fq, e.cyc, e.is_done, e.word);
            end
            if (!e.is_done) cur = e.word;
          end
        end
        if (!busy) cur = 32'h0;
        checks++;
        if (fq != cur) begin
          errors++;
          $display("FAIL hold cyc=%0d freqs=%h busy=%0b, required freqs=%h", cyc, fq, busy, cur);
        end
        done_prev = done;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  task automatic load_song(input int len);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
      mem[i] = w;
    end
    mem[len] = 32'hFFFF_FFFF;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({name, "_drain"}, 64'(expq.size()), 64'd0);
    check({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
    expq.delete();
  endtask

  // One playback. stop_after>0 pulses stop so that it is sampled stop_after
  // cycles after the FETCH cycle; restart_mid pulses start while busy.
  task automatic play(input string name, input int ticks, input bit lp, input int stop_after,
                      input bit restart_mid, input bit start_with_stop);
    int s;
    @(negedge clk);
    step_ticks = TICK_W'(ticks);
    loop_en    = lp;
    start      = 1'b1;
    s          = cyc + 1;
    model(s, ticks, lp, (stop_after > 0) ? s + stop_after : s + 50000);
    $display("song %s start_cyc=%0d ticks=%0d loop=%0b stop_after=%0d events=%0d",
             name, s, ticks, lp, stop_after, expq.size());
    @(negedge clk);
    start      = 1'b0;
    step_ticks = TICK_W'($urandom_range(0, 20));
    if (restart_mid) begin
      repeat (3) @(negedge clk);
      start      = 1'b1;
      step_ticks = TICK_W'(ticks + 3);
      @(negedge clk);
      start = 1'b0;
    end
    if (stop_after > 0) begin
      while (cyc < s + stop_after - 1) @(negedge clk);
      stop  = 1'b1;
      start = start_with_stop;
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
      check({name, "_stop_busy"}, {63'd0, busy}, 64'd0);
      check({name, "_stop_rd"}, {63'd0, mif.mem_rd}, 64'd0);
      check({name, "_stop_freq"}, {32'd0, freq4, freq3, freq2, freq1}, 64'd0);
    end
    drain(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, ticks, sa, s;
    bit lp, rm;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; step_ticks = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {20'd0, freq4, freq3, freq2, freq1, mif.mem_addr, mif.mem_rd, step_strobe, busy, done},
          64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic playback from the worked example.
    mem[0] = 32'h0403_0201; mem[1] = 32'h0807_0605; mem[2] = 32'hFFFF_FFFF;
    play("basic", 4, 1'b0, 0, 1'b0, 1'b0);
    check("basic_done", {63'd0, done}, 64'd1);
    // Looping with the same memory; 8-cycle dwell on the last step.
    play("loop", 4, 1'b1, 50, 1'b0, 1'b0);
    // Start while busy and step_ticks change mid-song: no effect.
    play("restart_busy", 4, 1'b0, 0, 1'b1, 1'b0);
    // Stop 20 cycles into step 0, then replay from address 0.
    play("stop_hold", 100, 1'b0, 22, 1'b0, 1'b0);
    play("replay", 2, 1'b0, 0, 1'b0, 1'b0);
    // start and stop together while busy.
    play("start_stop", 3, 1'b1, 9, 1'b0, 1'b1);
    // End marker at address 0 with looping: done after 3 cycles, no strobe.
    mem[0] = 32'hFFFF_FFFF;
    play("empty_loop", 3, 1'b1, 0, 1'b0, 1'b0);
    check("empty_done", {63'd0, done}, 64'd1);

    // start with step_ticks=0 is ignored.
    @(negedge clk);
    start = 1'b1; step_ticks = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("zero_ticks_idle", {62'd0, busy, mif.mem_rd}, 64'd0);
    end

    // Address wrap: full memory with no marker.
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'hFFFF_FFFF) mem[i] = 32'h1;
    end
    play("wrap", 1, 1'b0, DEPTH * 3 + 20, 1'b0, 1'b0);

    // Randomized songs.
    for (int n = 0; n < 30; n++) begin
      len   = $urandom_range(0, 5);
      ticks = $urandom_range(1, 6);
      lp    = 1'($urandom_range(0, 1));
      load_song(len);
      if (lp && len > 0) sa = $urandom_range(6, 80);
      else sa = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 40) : 0;
      rm = (len >= 1) && ($urandom_range(0, 1) == 1);
      play($sformatf("rand%0d", n), ticks, lp, sa, rm, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset during HOLD.
    mem[0] = 32'h0403_0201; mem[1] = 32'h0807_0605; mem[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    step_ticks = 16'd50; loop_en = 1'b0; start = 1'b1;
    s = cyc + 1;
    model(s, 50, 1'b0, s + 12);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 12) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {20'd0, freq4, freq3, freq2, freq1, mif.mem_addr, mif.mem_rd, step_strobe, busy, done},
          64'd0);
    check("async_reset_events", 64'(expq.size()), 64'd0);
    expq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_reset_idle", {61'd0, busy, mif.mem_rd, step_strobe}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
